// File: rtl/sram_port_arb.sv
// Round-robin arbiter multiplexing NUM_CH request channels onto one single-port SRAM.
// Optional macro SRAM_ARB_LOCK_EN adds a per-channel lock input that holds the grant.
module sram_port_arb #(
    parameter int NUM_CH     = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NUM_CH-1:0]            lock,
`endif
    output logic [NUM_CH-1:0]            gnt,
    output logic                         CEN,
    output logic                         WEN,
    output logic [ADDR_WIDTH-1:0]        A,
    output logic [DATA_WIDTH-1:0]        D,
    input  logic [DATA_WIDTH-1:0]        Q,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [NUM_CH-1:0]            rvalid
);

    localparam int PW = $clog2(NUM_CH);

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gch;
    logic                  found;
    int unsigned           start;
    int unsigned           idx;
    logic [PW-1:0]         ix;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  cen_q, wen_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic [PW-1:0]         ch_q;

    logic [RD_LAT-1:0]     tag_vld_q;
    logic [PW-1:0]         tag_ch_q [RD_LAT];

`ifdef SRAM_ARB_LOCK_EN
    logic                  held_q;
    logic [PW-1:0]         held_ch_q;
    logic                  hold_now;
`endif

    // While a lock is held, ptr is frozen; the search restarts just past the held channel.
    always_comb begin
        start = 32'(ptr_q);
`ifdef SRAM_ARB_LOCK_EN
        if (held_q) begin
            start = (32'(held_ch_q) == 32'(NUM_CH - 1)) ? 0 : 32'(held_ch_q) + 1;
        end
`endif
        found = 1'b0;
        gch   = '0;
        idx   = 0;
        ix    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = start + i;
            if (idx >= 32'(NUM_CH)) idx = idx - 32'(NUM_CH);
            ix = idx[PW-1:0];
            if (!found && req[ix]) begin
                found = 1'b1;
                gch   = ix;
            end
        end
`ifdef SRAM_ARB_LOCK_EN
        hold_now = held_q && req[held_ch_q] && lock[held_ch_q];
        if (hold_now) begin
            found = 1'b1;
            gch   = held_ch_q;
        end
`endif
        if (!rst_n) found = 1'b0;
    end

    always_comb begin
        gnt       = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (found && (PW'(i) == gch)) begin
                gnt[i]    = 1'b1;
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef SRAM_ARB_LOCK_EN
        if (found && !lock[gch]) begin
`else
        if (found) begin
`endif
            ptr_d = (gch == PW'(NUM_CH - 1)) ? '0 : gch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cen_q     <= 1'b1;
            wen_q     <= 1'b1;
            a_q       <= '1;
            d_q       <= '0;
            ch_q      <= '0;
            tag_vld_q <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) tag_ch_q[s] <= '0;
`ifdef SRAM_ARB_LOCK_EN
            held_q    <= 1'b0;
            held_ch_q <= '0;
`endif
        end else begin
            ptr_q <= ptr_d;
            cen_q <= ~found;
            wen_q <= ~(found & sel_we);
            a_q   <= found ? sel_addr : '1;
            d_q   <= found ? sel_wdata : '0;
            ch_q  <= gch;
            // Tag enters the pipe at the end of the cycle the read is presented to the SRAM.
            tag_vld_q[0] <= ~cen_q & wen_q;
            tag_ch_q[0]  <= ch_q;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_ch_q[s]  <= tag_ch_q[s-1];
            end
`ifdef SRAM_ARB_LOCK_EN
            held_q    <= found & lock[gch];
            held_ch_q <= gch;
`endif
        end
    end

    always_comb begin
        rvalid = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (tag_vld_q[RD_LAT-1] && (tag_ch_q[RD_LAT-1] == PW'(i))) rvalid[i] = 1'b1;
        end
    end

    assign CEN   = cen_q;
    assign WEN   = wen_q;
    assign A     = a_q;
    assign D     = d_q;
    assign rdata = Q;

endmodule
